// File: rtl/int_pkg.sv
// int_pkg: shared constants, FSM encoding and counter sizing for ext_int_dispatcher.
package int_pkg;
  localparam int NUM_EXT_INT = 4;
  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK, GAP} state_t;
  function automatic int to_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/int_src_counter.sv
// int_src_counter: per-source input register, rising-edge detect and saturating pending counter.
module int_src_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src_irq,
  input  logic grant,
  input  logic ovf_clr,
  output logic pending,
  output logic ovf
);
  logic src_q, src_p, ev, sat;
  logic [CNT_W-1:0] cnt;
  assign ev = src_q & ~src_p;
  assign sat = &cnt;
  assign pending = |cnt;
  // an event that coincides with a grant is absorbed, so it is never dropped
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      src_q <= 1'b0;
      src_p <= 1'b0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      src_q <= src_irq;
      src_p <= src_q;
      cnt <= (ev && !grant && !sat) ? cnt + 1'b1 : (grant && !ev) ? cnt - 1'b1 : cnt;
      ovf <= (ev && sat && !grant) | (ovf & ~ovf_clr);
    end
endmodule

// File: rtl/ext_int_dispatcher.sv
// ext_int_dispatcher: counts peripheral IRQ edges and issues one ext_intN pulse at a time,
// holding off until the CPU acknowledges with a reti edge or the ack timeout expires.
module ext_int_dispatcher
  import int_pkg::*;
#(
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN = 2,
  parameter int ACK_TIMEOUT = 1024,
  parameter int CNT_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_EXT_INT-1:0] src_irq,
  input  logic [NUM_EXT_INT-1:0] irq_mask,
  input  logic                   reti,
  input  logic                   ovf_clr,
  output logic                   ext_int1,
  output logic                   ext_int2,
  output logic                   ext_int3,
  output logic                   ext_int4,
  output logic [NUM_EXT_INT-1:0] pending,
  output logic                   busy,
  output logic [NUM_EXT_INT-1:0] ovf,
  output logic                   timeout_err
);
  localparam int SW = $clog2(NUM_EXT_INT);
  localparam int LONGEST = (ACK_TIMEOUT > PULSE_LEN && ACK_TIMEOUT > GAP_LEN) ? ACK_TIMEOUT :
                           (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CW = to_w(LONGEST);
  localparam logic [CW-1:0] P_END = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] G_END = CW'(GAP_LEN - 1);
  localparam logic [CW-1:0] T_END = CW'(ACK_TIMEOUT - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] sel, win;
  logic [NUM_EXT_INT-1:0] elig, grant, ext_v;
  logic reti_q, reti_p, reti_ev, to_hit;
  for (genvar i = 0; i < NUM_EXT_INT; i++) begin : g_src
    int_src_counter #(.CNT_W(CNT_W)) u_src (
      .clk(clk),
      .reset(reset),
      .src_irq(src_irq[i]),
      .grant(grant[i]),
      .ovf_clr(ovf_clr),
      .pending(pending[i]),
      .ovf(ovf[i])
    );
  end
  assign elig = pending & irq_mask;
  assign reti_ev = reti_q & ~reti_p;
  // lowest index wins: scan from the top so the last hit is the smallest
  always_comb begin
    win = '0;
    for (int i = NUM_EXT_INT - 1; i >= 0; i--) win = elig[i] ? SW'(i) : win;
  end
  assign grant = (state == IDLE && |elig) ? NUM_EXT_INT'(1) << win : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      sel <= '0;
      reti_q <= 1'b0;
      reti_p <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sel <= (state == IDLE) ? win : sel;
      reti_q <= reti;
      reti_p <= reti_q;
      timeout_err <= to_hit | (timeout_err & ~ovf_clr);
    end
  always_comb begin
    state_n = state;
    cnt_n = '0;
    to_hit = 1'b0;
    case (state)
      IDLE: state_n = |elig ? ASSERT : IDLE;
      ASSERT: begin
        state_n = (cnt == P_END) ? WAIT_ACK : ASSERT;
        cnt_n = (cnt == P_END) ? '0 : cnt + 1'b1;
      end
      WAIT_ACK: begin
        to_hit = !reti_ev && ACK_TIMEOUT != 0 && cnt == T_END;
        state_n = (reti_ev || to_hit) ? GAP : WAIT_ACK;
        cnt_n = (reti_ev || to_hit || ACK_TIMEOUT == 0) ? '0 : cnt + 1'b1;
      end
      default: begin
        state_n = (cnt == G_END) ? IDLE : GAP;
        cnt_n = (cnt == G_END) ? '0 : cnt + 1'b1;
      end
    endcase
  end
  always_comb begin
    ext_v = (state == ASSERT) ? NUM_EXT_INT'(1) << sel : '0;
    busy = state != IDLE;
  end
  assign ext_int1 = ext_v[0];
  assign ext_int2 = ext_v[1];
  assign ext_int3 = ext_v[2];
  assign ext_int4 = ext_v[3];
endmodule

// File: tb/tb_ext_int_dispatcher.sv
// tb_ext_int_dispatcher: directed test-plan scenarios plus random traffic, checked every cycle
// against a timeline model of dispatch windows and per-source event counts.
module tb_ext_int_dispatcher;
  localparam int P = 2;
  localparam int G = 2;
  localparam int TO = 16;
  localparam int CMAX = 3;
  localparam int INF = 32'h7fffffff;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] src_irq = '0;
  logic [3:0] irq_mask = 4'hf;
  logic reti = 1'b0;
  logic ovf_clr = 1'b0;
  logic ext_int1, ext_int2, ext_int3, ext_int4, busy, timeout_err;
  logic [3:0] pending, ovf, ext;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mcnt [4];
  logic [3:0] movf, ms1, ms2;
  logic mterr, mr1, mr2;
  bit mact;
  int msrc, mtw, mti;
  assign ext = {ext_int4, ext_int3, ext_int2, ext_int1};
  always #5 clk = ~clk;
  ext_int_dispatcher #(.PULSE_LEN(P), .GAP_LEN(G), .ACK_TIMEOUT(TO), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .irq_mask(irq_mask), .reti(reti),
    .ovf_clr(ovf_clr), .ext_int1(ext_int1), .ext_int2(ext_int2), .ext_int3(ext_int3),
    .ext_int4(ext_int4), .pending(pending), .busy(busy), .ovf(ovf), .timeout_err(timeout_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic model_reset();
    for (int n = 0; n < 4; n++) mcnt[n] = 0;
    movf = '0; ms1 = '0; ms2 = '0; mterr = 1'b0; mr1 = 1'b0; mr2 = 1'b0;
    mact = 0; msrc = 0; mtw = 0; mti = INF;
  endtask
  // one clock edge: a dispatch occupies [grant+1, mtw) as pulse, then waits for ack until mti
  task automatic model_step();
    logic [3:0] ev, elig, g;
    bit rev, tset;
    int w, nc;
    ev = ms1 & ~ms2;
    rev = mr1 & ~mr2;
    g = '0;
    tset = 0;
    if (mact && cyc >= mti) mact = 0;
    for (int n = 0; n < 4; n++) elig[n] = (mcnt[n] != 0) && irq_mask[n];
    if (!mact && elig != 0) begin
      w = 0;
      while (!elig[w]) w++;
      g[w] = 1'b1; mact = 1; msrc = w; mtw = cyc + 1 + P; mti = INF;
    end else if (mact && cyc >= mtw && mti == INF) begin
      if (rev) mti = cyc + 1 + G;
      else if (cyc == mtw + TO - 1) begin mti = cyc + 1 + G; tset = 1; end
    end
    if (ovf_clr) begin movf = '0; mterr = 1'b0; end
    if (tset) mterr = 1'b1;
    for (int n = 0; n < 4; n++) begin
      nc = mcnt[n] + int'(ev[n]) - int'(g[n]);
      if (nc > CMAX) begin nc = CMAX; movf[n] = 1'b1; end
      mcnt[n] = nc;
    end
    ms2 = ms1; ms1 = src_irq; mr2 = mr1; mr1 = reti;
  endtask
  task automatic compare();
    logic [3:0] eext, epend;
    eext = (mact && cyc < mtw) ? 4'b0001 << msrc : 4'b0000;
    for (int n = 0; n < 4; n++) epend[n] = mcnt[n] != 0;
    check("ext", ext, eext);
    check("onehot", $countones(ext) <= 1, 1);
    check("pending", pending, epend);
    check("busy", busy, mact && cyc < mti);
    check("ovf", ovf, movf);
    check("timeout_err", timeout_err, mterr);
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_ext", ext, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_ovf", ovf, 0);
    check("rst_terr", timeout_err, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic wait_ext(input int idx, input int lat);
    int n = 0;
    while (!ext[idx] && n < 20) begin tick(); n++; end
    check("latency", n, lat);
  endtask
  task automatic ack();
    reti = 1'b1; run(2); reti = 1'b0;
  endtask
  initial begin
    #3;
    do_reset();
    run(3);
    src_irq[1] = 1'b1;
    wait_ext(1, 3);
    run(6);
    ack();
    run(8);
    src_irq = '0;
    run(3);
    src_irq = 4'b1001;
    wait_ext(0, 3);
    run(3);
    ack();
    run(8);
    ack();
    run(8);
    src_irq = '0;
    irq_mask = 4'b1011;
    for (int i = 0; i < 5; i++) begin src_irq[2] = 1'b1; run(2); src_irq[2] = 1'b0; run(2); end
    check("sat_ovf2", ovf[2], 1);
    irq_mask = 4'hf;
    for (int i = 0; i < 3; i++) begin run(6); ack(); end
    run(10);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    run(3);
    src_irq = 4'b1001;
    wait_ext(0, 3);
    run(60);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    src_irq = '0;
    run(3);
    src_irq[1] = 1'b1;
    wait_ext(1, 3);
    tick();
    do_reset();
    src_irq = '0;
    run(40);
    src_irq[0] = 1'b1;
    run(10);
    reti = 1'b1;
    run(90);
    src_irq = '0;
    reti = 1'b0;
    run(30);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) src_irq = src_irq ^ 4'($urandom);
      if ($urandom_range(0, 15) == 0) irq_mask = 4'($urandom);
      if ($urandom_range(0, 5) == 0) reti = ~reti;
      ovf_clr = $urandom_range(0, 40) == 0;
      if ($urandom_range(0, 999) == 0) do_reset();
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
